// File: rtl/seg_frame_decoder.sv
// Receive-side decoder for an 8-digit multiplexed seven-segment bus: synchronizes AN/CA,
// rejects scan glitches, decodes digits back to hex and assembles/compares full frames.
module seg_frame_decoder #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  an,
    input  logic [7:0]  ca,
    output logic [31:0] frame,
    output logic        frame_valid,
    output logic        scroll_evt,
    output logic        an_err,
    output logic        seg_err,
    output logic [7:0]  digits_seen
);

    localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

    logic [15:0] sync1, sync2, word_q;
    logic [7:0]  hold_cnt, hold_next;
    logic        word_changed, strobe;
    logic [31:0] digits_q;
    logic        prev_valid;

    logic [7:0]  an_low;
    logic        single_low, multi_low;
    logic [4:0]  dec;

    // Returns {legal, code}; ca is active-low with bit order g,f,e,d,c,b,a.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h40: decode = 5'h10;
            7'h79: decode = 5'h11;
            7'h24: decode = 5'h12;
            7'h30: decode = 5'h13;
            7'h19: decode = 5'h14;
            7'h12: decode = 5'h15;
            7'h02: decode = 5'h16;
            7'h78: decode = 5'h17;
            7'h00: decode = 5'h18;
            7'h10: decode = 5'h19;
            7'h08: decode = 5'h1A;
            7'h03: decode = 5'h1B;
            7'h46: decode = 5'h1C;
            7'h21: decode = 5'h1D;
            7'h06: decode = 5'h1E;
            7'h0E: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    // hold_cnt holds the previous cycle's count, so hold_next is the count including this cycle.
    always_comb begin
        word_changed = (sync2 != word_q);
        hold_next    = hold_cnt;
        if (word_changed) begin
            hold_next = 8'd1;
        end else if (hold_cnt >= STABLE_W) begin
            hold_next = STABLE_W;
        end else begin
            hold_next = hold_cnt + 8'd1;
        end
        strobe = !word_changed && (hold_cnt == STABLE_W - 8'd1);

        an_low     = ~sync2[15:8];
        single_low = (an_low != 8'h00) && ((an_low & (an_low - 8'd1)) == 8'h00);
        multi_low  = (an_low != 8'h00) && !single_low;
        dec        = decode(sync2[6:0]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1       <= 16'hFFFF;
            sync2       <= 16'hFFFF;
            word_q      <= 16'hFFFF;
            hold_cnt    <= 8'd0;
            digits_q    <= 32'h0;
            digits_seen <= 8'h00;
            frame       <= 32'h0;
            prev_valid  <= 1'b0;
            frame_valid <= 1'b0;
            scroll_evt  <= 1'b0;
            an_err      <= 1'b0;
            seg_err     <= 1'b0;
        end else begin
            sync1       <= {an, ca};
            sync2       <= sync1;
            word_q      <= sync2;
            hold_cnt    <= hold_next;
            frame_valid <= 1'b0;
            scroll_evt  <= 1'b0;
            an_err      <= strobe && multi_low;
            seg_err     <= strobe && single_low && !dec[4];

            if (strobe && single_low && dec[4]) begin
                for (int k = 0; k < 8; k++) begin
                    if (an_low[k]) begin
                        digits_q[4*k +: 4] <= dec[3:0];
                        digits_seen[k]     <= 1'b1;
                    end
                end
            end

            // The clear comes after any digit write so a same-cycle capture never carries over.
            if (digits_seen == 8'hFF) begin
                frame       <= digits_q;
                frame_valid <= 1'b1;
                scroll_evt  <= prev_valid && (digits_q[31:4] == frame[27:0]) && (digits_q != frame);
                prev_valid  <= 1'b1;
                digits_seen <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Directed plus randomized scan stimulus for seg_frame_decoder, checked against a
// word/hold-level model of the display protocol.
module tb_seg_frame_decoder;

    localparam int S = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  an;
    logic [7:0]  ca;
    logic [31:0] frame;
    logic        frame_valid, scroll_evt, an_err, seg_err;
    logic [7:0]  digits_seen;

    int errors = 0;
    int checks = 0;

    seg_frame_decoder #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .an(an), .ca(ca),
        .frame(frame), .frame_valid(frame_valid), .scroll_evt(scroll_evt),
        .an_err(an_err), .seg_err(seg_err), .digits_seen(digits_seen)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [6:0]  seg_tab [16];
    logic [3:0]  m_digit [8];
    logic [7:0]  m_seen;
    logic [31:0] m_frame;
    bit          m_pv;
    logic [15:0] m_word;
    int          m_len;
    int          m_fv, m_sc, m_ae, m_se;
    logic [31:0] exp_q [$];
    logic [31:0] exp_sq [$];

    // Observed pulse counts
    int fv_cnt = 0, sc_cnt = 0, ae_cnt = 0, se_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (frame_valid) begin
                fv_cnt++;
                check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("frame_value", frame, exp_q.pop_front());
                    check("frame_scroll", 32'(scroll_evt), exp_sq.pop_front());
                end
            end
            if (scroll_evt) sc_cnt++;
            if (an_err) ae_cnt++;
            if (seg_err) se_cnt++;
        end
    end

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_digit[k] = 4'h0;
        m_seen  = 8'h00;
        m_frame = 32'h0;
        m_pv    = 1'b0;
        m_word  = 16'hFFFF;
        m_len   = 0;
    endtask

    task automatic model_capture(input logic [15:0] w);
        logic [7:0]  lows;
        logic [31:0] nf;
        int k, code;
        lows = ~w[15:8];
        if (lows == 8'h00) return;
        if ($countones(lows) > 1) begin
            m_ae++;
            return;
        end
        k = 0;
        for (int i = 0; i < 8; i++) if (lows[i]) k = i;
        code = -1;
        for (int c = 0; c < 16; c++) if (seg_tab[c] == w[6:0]) code = c;
        if (code < 0) begin
            m_se++;
            return;
        end
        m_digit[k] = 4'(code);
        m_seen[k]  = 1'b1;
        if (m_seen == 8'hFF) begin
            nf = 32'h0;
            for (int i = 0; i < 8; i++) nf[4*i +: 4] = m_digit[i];
            exp_q.push_back(nf);
            if (m_pv && nf[31:4] == m_frame[27:0] && nf != m_frame) begin
                exp_sq.push_back(32'd1);
                m_sc++;
            end else begin
                exp_sq.push_back(32'd0);
            end
            m_fv++;
            m_frame = nf;
            m_pv    = 1'b1;
            m_seen  = 8'h00;
        end
    endtask

    // A word is captured once its unbroken run (merged across steps) first reaches S cycles.
    task automatic drive(input logic [15:0] w, input int n);
        int old_len;
        old_len = (w == m_word) ? m_len : 0;
        m_word  = w;
        m_len   = old_len + n;
        if (old_len < S && m_len >= S) model_capture(w);
        an = w[15:8];
        ca = w[7:0];
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] digit_word(input int k, input logic [3:0] d);
        logic [7:0] a;
        a = ~(8'h01 << k);
        return {a, 1'b1, seg_tab[d]};
    endfunction

    task automatic scan(input logic [31:0] f, input int n);
        for (int k = 7; k >= 0; k--) drive(digit_word(k, f[4*k +: 4]), n);
    endtask

    task automatic checkpoint(input string tag);
        drive(16'hFFFF, 8);
        check({tag, "_fv"}, fv_cnt, m_fv);
        check({tag, "_sc"}, sc_cnt, m_sc);
        check({tag, "_ae"}, ae_cnt, m_ae);
        check({tag, "_se"}, se_cnt, m_se);
        check({tag, "_seen"}, digits_seen, m_seen);
        check({tag, "_frame"}, frame, m_frame);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        an = 8'hFF;
        ca = 8'hFF;
        repeat (n) @(posedge clk);
        #1;
        model_reset();
        check("rst_frame", frame, 32'h0);
        check("rst_seen", digits_seen, 8'h00);
        check("rst_pulses", {frame_valid, scroll_evt, an_err, seg_err}, 4'b0000);
        reset = 1'b1;
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        m_fv = 0; m_sc = 0; m_ae = 0; m_se = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(3);

        // Static scan, then scroll, then identical repeat
        scan(32'h01234567, 20);
        checkpoint("static");
        check("static_frame_const", frame, 32'h01234567);
        check("static_no_scroll", sc_cnt, 0);
        scan(32'h12345670, 20);
        checkpoint("scroll");
        check("scroll_frame_const", frame, 32'h12345670);
        check("scroll_pulse_const", sc_cnt, 1);
        scan(32'h12345670, 20);
        checkpoint("repeat");
        check("repeat_fv_const", fv_cnt, 3);
        check("repeat_sc_const", sc_cnt, 1);

        // Glitch between digits must not disturb digit 2
        for (int k = 7; k >= 0; k--) begin
            drive(digit_word(k, 4'(k + 8)), 20);
            if (k == 4) drive({8'b11111011, 8'h80}, 10);
        end
        checkpoint("glitch");
        check("glitch_frame_const", frame, 32'hFEDCBA98);

        // Error cases
        drive({8'b11111100, 8'hC0}, 20);
        checkpoint("an_err");
        check("an_err_const", ae_cnt, 1);
        drive({8'b11111110, 8'hFF}, 20);
        checkpoint("seg_err");
        check("seg_err_const", se_cnt, 1);
        check("seg_err_seen0", 32'(digits_seen[0]), 32'd0);

        // Reset mid-frame
        for (int k = 0; k < 5; k++) drive(digit_word(k, 4'(k)), 20);
        checkpoint("partial");
        check("partial_seen_const", digits_seen, 8'h1F);
        do_reset(1);
        scan(32'h23456701, 20);
        checkpoint("post_reset");
        check("post_reset_no_scroll", sc_cnt, 1);

        // Blank and long hold
        drive(16'hFFFF, 1000);
        checkpoint("blank");
        drive(digit_word(3, 4'h9), 1000);
        checkpoint("long_hold");
        check("long_hold_seen_const", digits_seen, 8'h08);

        // Randomized scans, scrolls and stray words
        for (int it = 0; it < 12; it++) begin
            logic [31:0] f;
            f = $urandom;
            scan(f, $urandom_range(S, 24));
            scan({f[27:0], 4'($urandom_range(0, 15))}, $urandom_range(S, 24));
            for (int j = 0; j < 10; j++) begin
                int r, n;
                logic [15:0] w;
                r = $urandom_range(0, 9);
                n = $urandom_range(4, 30);
                if (r <= 6) w = digit_word($urandom_range(0, 7), 4'($urandom_range(0, 15)));
                else if (r == 7) w = {~(8'h01 << $urandom_range(0, 7)), 1'b1, 7'($urandom_range(0, 127))};
                else if (r == 8) w = {8'($urandom_range(0, 254)) & 8'hBF, 8'h80};
                else w = 16'hFFFF;
                drive(w, n);
            end
            checkpoint("random");
        end

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
